// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - SVGA 800x600@60Hz timing constants shared by the video chain
package vga_pkg;

  localparam int COUNT_W = 11;
  localparam int RGB_W   = 12;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL_DEFAULT = 1'b1;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA raster stream between the timing source and draw stages
interface vga_if;
  import vga_pkg::*;

  logic [COUNT_W-1:0] vcount;
  logic               vsync;
  logic               vblnk;
  logic [COUNT_W-1:0] hcount;
  logic               hsync;
  logic               hblnk;
  logic [RGB_W-1:0]   rgb;

  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with registered blank/sync decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   ACTIVE   = H_ACTIVE,
  parameter int   FP       = H_FP,
  parameter int   SYNC     = H_SYNC,
  parameter int   BP       = H_BP,
  parameter logic SYNC_POL = SYNC_POL_DEFAULT
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COUNT_W-1:0] count,
  output logic               blnk,
  output logic               sync,
  output logic               tc
);

  localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [COUNT_W-1:0] BLNK_START = COUNT_W'(ACTIVE);
  localparam logic [COUNT_W-1:0] SYNC_START = COUNT_W'(ACTIVE + FP);
  localparam logic [COUNT_W-1:0] SYNC_END   = COUNT_W'(ACTIVE + FP + SYNC);

  logic [COUNT_W-1:0] count_q, count_d;
  logic               blnk_q, blnk_d;
  logic               sync_q, sync_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + COUNT_W'(1);
    end
    // decode from the next count so blank/sync line up with the count they are shown with
    blnk_d = (count_d >= BLNK_START);
    sync_d = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= ~SYNC_POL;
    end else begin
      count_q <= count_d;
      blnk_q  <= blnk_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign blnk  = blnk_q;
  assign sync  = sync_q;
  assign tc    = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster source: chained h/v counters driving vga_if.out
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL_DEFAULT
)(
  input  logic  clk,
  input  logic  rst,
  vga_if.out    vga_out,
  output logic  frame_start
);

  logic [COUNT_W-1:0] hcount, vcount;
  logic               hblnk, hsync, h_tc;
  logic               vblnk, vsync, v_tc;
  logic               frame_start_q, frame_start_d;

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_h_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (hcount),
    .blnk  (hblnk),
    .sync  (hsync),
    .tc    (h_tc)
  );

  // vertical axis advances only on the last pixel of each line
  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_v_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (h_tc),
    .count (vcount),
    .blnk  (vblnk),
    .sync  (vsync),
    .tc    (v_tc)
  );

  // both terminal counts now means the next presented pixel is (0,0)
  assign frame_start_d = h_tc && v_tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start    = frame_start_q;
  assign vga_out.hcount = hcount;
  assign vga_out.hsync  = hsync;
  assign vga_out.hblnk  = hblnk;
  assign vga_out.vcount = vcount;
  assign vga_out.vsync  = vsync;
  assign vga_out.vblnk  = vblnk;
  assign vga_out.rgb    = '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: full SVGA line checks plus scaled-raster frame checks
module tb_vga_timing_gen;
  import vga_pkg::*;

  // scaled raster so whole frames fit in a short run: 32 x 18 = 576 clk per frame
  localparam int SHA = 16, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVA = 12, SVF = 1, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_f = 1'b1;
  logic rst_s = 1'b1;
  logic fs_f, fs_s;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pf = 0;
  int   ps = 0;
  obs_t got, exp_o;

  vga_if vif_f ();
  vga_if vif_s ();

  vga_timing_gen dut_full (
    .clk         (clk),
    .rst         (rst_f),
    .vga_out     (vif_f.out),
    .frame_start (fs_f)
  );

  vga_timing_gen #(
    .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
    .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
    .SYNC_POL (1'b1)
  ) dut_small (
    .clk         (clk),
    .rst         (rst_s),
    .vga_out     (vif_s.out),
    .frame_start (fs_s)
  );

  // p = number of clock edges since reset was released (0 while in reset)
  function automatic obs_t model(int p, int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb);
    obs_t m;
    int ht, vt, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h = p % ht;
    v = (p / ht) % vt;
    m.h     = 11'(h);
    m.v     = 11'(v);
    m.hblnk = (h >= ha);
    m.vblnk = (v >= va);
    m.hsync = (h >= ha + hf) && (h < ha + hf + hs);
    m.vsync = (v >= va + vf) && (v < va + vf + vs);
    m.rgb   = 12'h000;
    m.fs    = (p > 0) && (p % (ht * vt) == 0);
    return m;
  endfunction

  function automatic obs_t model_f(int p);
    return model(p, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP);
  endfunction

  function automatic obs_t model_s(int p);
    return model(p, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
  endfunction

  function automatic obs_t obs_f();
    return {vif_f.hcount, vif_f.vcount, vif_f.hsync, vif_f.vsync, vif_f.hblnk, vif_f.vblnk, vif_f.rgb, fs_f};
  endfunction

  function automatic obs_t obs_s();
    return {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk, vif_s.vblnk, vif_s.rgb, fs_s};
  endfunction

  task automatic test_reset();
    rst_f = 1'b1; rst_s = 1'b1; pf = 0; ps = 0;
    repeat (5) begin
      @(negedge clk);
      got = obs_f(); exp_o = model_f(0);
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL reset_full got=%h exp=%h", got, exp_o);
      end
      got = obs_s(); exp_o = model_s(0);
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL reset_small got=%h exp=%h", got, exp_o);
      end
    end
    rst_f = 1'b0; pf = 1;
    @(negedge clk);
    n_tests++;
    if (vif_f.hcount !== 11'd1) begin
      n_fail++;
      $display("FAIL first_edge_hcount got=%0d exp=1", vif_f.hcount);
    end
  endtask

  task automatic test_one_line();
    int hs_cnt = 0;
    bit wrap_seen = 1'b0;
    logic [10:0] prev_h = vif_f.hcount;
    logic [10:0] prev_v = vif_f.vcount;
    for (int i = 0; i < 1060; i++) begin
      pf++;
      @(negedge clk);
      got = obs_f(); exp_o = model_f(pf);
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL line_full p=%0d got=%h exp=%h", pf, got, exp_o);
      end
      if (got.hsync === 1'b1) hs_cnt++;
      if (prev_h == 11'd1055 && prev_v == 11'd0 && got.h == 11'd0 && got.v == 11'd1) wrap_seen = 1'b1;
      prev_h = got.h;
      prev_v = got.v;
    end
    n_tests++;
    if (hs_cnt != H_SYNC) begin
      n_fail++;
      $display("FAIL hsync_width got=%0d exp=%0d", hs_cnt, H_SYNC);
    end
    n_tests++;
    if (!wrap_seen) begin
      n_fail++;
      $display("FAIL line_wrap got=no_wrap exp=1055->0_with_vcount_0->1");
    end
    rst_f = 1'b1;
  endtask

  task automatic test_two_frames();
    int fs_cnt = 0, vs_cnt = 0, vb_cnt = 0;
    rst_s = 1'b0;
    for (int i = 0; i < 2 * SFRAME + 4; i++) begin
      ps++;
      @(negedge clk);
      got = obs_s(); exp_o = model_s(ps);
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL frame_small p=%0d got=%h exp=%h", ps, got, exp_o);
      end
      if (got.fs === 1'b1) fs_cnt++;
      if (got.vsync === 1'b1) vs_cnt++;
      if (got.vblnk === 1'b1) vb_cnt++;
    end
    n_tests++;
    if (fs_cnt != 2) begin
      n_fail++;
      $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
    end
    n_tests++;
    if (vs_cnt != 2 * SVS * SHT) begin
      n_fail++;
      $display("FAIL vsync_cycles got=%0d exp=%0d", vs_cnt, 2 * SVS * SHT);
    end
    n_tests++;
    if (vb_cnt != 2 * (SVT - SVA) * SHT) begin
      n_fail++;
      $display("FAIL vblnk_cycles got=%0d exp=%0d", vb_cnt, 2 * (SVT - SVA) * SHT);
    end
  endtask

  task automatic test_boundary_wrap();
    int guard = 0;
    while ((ps % SFRAME) != SFRAME - 1 && guard < 2 * SFRAME) begin
      ps++; guard++;
      @(negedge clk);
    end
    n_tests++;
    if (vif_s.hcount !== 11'(SHT - 1) || vif_s.vcount !== 11'(SVT - 1)) begin
      n_fail++;
      $display("FAIL wrap_position got=(%0d,%0d) exp=(%0d,%0d)", vif_s.hcount, vif_s.vcount, SHT - 1, SVT - 1);
    end
    ps++;
    @(negedge clk);
    got = obs_s();
    exp_o = '0;
    exp_o.fs = 1'b1;
    n_tests++;
    if (got !== exp_o) begin
      n_fail++;
      $display("FAIL wrap_to_origin got=%h exp=%h", got, exp_o);
    end
    ps++;
    @(negedge clk);
    n_tests++;
    if (fs_s !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_start_one_cycle got=%b exp=0", fs_s);
    end
  endtask

  task automatic test_mid_frame_reset();
    int guard = 0;
    int fs_cnt = 0;
    int target = (SVA / 2) * SHT + SHA / 2;
    while ((ps % SFRAME) != target && guard < 2 * SFRAME) begin
      ps++; guard++;
      @(negedge clk);
    end
    rst_s = 1'b1; ps = 0;
    @(negedge clk);
    got = obs_s(); exp_o = model_s(0);
    n_tests++;
    if (got !== exp_o) begin
      n_fail++;
      $display("FAIL mid_reset got=%h exp=%h", got, exp_o);
    end
    rst_s = 1'b0;
    for (int i = 0; i < SFRAME + 1; i++) begin
      ps++;
      @(negedge clk);
      got = obs_s(); exp_o = model_s(ps);
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL after_reset p=%0d got=%h exp=%h", ps, got, exp_o);
      end
      if (got.fs === 1'b1) fs_cnt++;
    end
    n_tests++;
    if (fs_cnt != 1) begin
      n_fail++;
      $display("FAIL restart_frame_start got=%0d exp=1", fs_cnt);
    end
  endtask

  task automatic test_random_resets();
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 700);
      int k = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        ps++;
        @(negedge clk);
        got = obs_s(); exp_o = model_s(ps);
        n_tests++;
        if (got !== exp_o) begin
          n_fail++;
          $display("FAIL random_run p=%0d got=%h exp=%h", ps, got, exp_o);
        end
      end
      rst_s = 1'b1; ps = 0;
      repeat (k) begin
        @(negedge clk);
        got = obs_s(); exp_o = model_s(0);
        n_tests++;
        if (got !== exp_o) begin
          n_fail++;
          $display("FAIL random_reset got=%h exp=%h", got, exp_o);
        end
      end
      rst_s = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_one_line();
    test_two_frames();
    test_boundary_wrap();
    test_mid_frame_reset();
    test_random_resets();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
